// File: rtl/game_state_pkg.sv
// rtl/game_state_pkg.sv - shared phase encoding and field widths for the game-flow controller
package game_state_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PLAY        = 3'd1,
        HIT_PAUSE   = 3'd2,
        CLEAR_PAUSE = 3'd3,
        LOST        = 3'd4,
        WON         = 3'd5
    } state_t;

    localparam int LIVES_W = 4;
    localparam int WAVE_W  = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// rtl/game_flow_ctrl_if.sv - game events in, phase/HUD/pulse outputs back
interface game_flow_ctrl_if #(
    parameter int NUM_ROWS     = 3,
    parameter int NUM_INVADERS = 10
);
    import game_state_pkg::*;

    logic                                     start;
    logic                                     player_hit;
    logic                                     invaders_landed;
    logic [NUM_ROWS-1:0][NUM_INVADERS-1:0]    alive;

    state_t                                   state;
    logic [LIVES_W-1:0]                       lives;
    logic [WAVE_W-1:0]                        wave;
    logic                                     freeze;
    logic                                     wave_start;
    logic                                     player_respawn;
    logic                                     game_lost;
    logic                                     game_won;

    modport master (
        output start, player_hit, invaders_landed, alive,
        input  state, lives, wave, freeze, wave_start, player_respawn, game_lost, game_won
    );

    modport slave (
        input  start, player_hit, invaders_landed, alive,
        output state, lives, wave, freeze, wave_start, player_respawn, game_lost, game_won
    );

endinterface

// File: rtl/pause_timer.sv
// rtl/pause_timer.sv - loadable down-counter; done is high for the last cycle of a timed run
module pause_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q, busy_d;

    always_comb begin
        count_d = count_q;
        busy_d  = busy_q;
        if (start) begin
            count_d = load_val;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (count_q == '0) begin
                busy_d = 1'b0;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign done = busy_q && (count_q == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - lives/waves state machine with timed respawn and wave-clear pauses
module game_flow_ctrl
    import game_state_pkg::*;
#(
    parameter int NUM_INVADERS   = 10,
    parameter int NUM_ROWS       = 3,
    parameter int NUM_LIVES      = 3,
    parameter int NUM_WAVES      = 4,
    parameter int RESPAWN_CYCLES = 65_000_000,
    parameter int CLEAR_CYCLES   = 65_000_000
) (
    input  logic           clk,
    input  logic           rst,
    game_flow_ctrl_if.slave gf
);

    localparam int TIMER_W = $clog2(max2(RESPAWN_CYCLES, CLEAR_CYCLES) + 1);

    state_t               state_q, state_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [WAVE_W-1:0]    wave_q, wave_d;
    logic                 freeze_q, freeze_d;
    logic                 wave_start_q, wave_start_d;
    logic                 player_respawn_q, player_respawn_d;
    logic                 game_lost_q, game_lost_d;
    logic                 game_won_q, game_won_d;

    logic                 tmr_start;
    logic [TIMER_W-1:0]   tmr_load;
    logic                 tmr_done;

    logic [NUM_ROWS*NUM_INVADERS-1:0] alive_flat;
    logic                             grid_empty;

    assign alive_flat = gf.alive;
    assign grid_empty = (alive_flat == '0);

    pause_timer #(.WIDTH(TIMER_W)) u_pause_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (tmr_start),
        .load_val (tmr_load),
        .done     (tmr_done)
    );

    always_comb begin
        state_d          = state_q;
        lives_d          = lives_q;
        wave_d           = wave_q;
        wave_start_d     = 1'b0;
        player_respawn_d = 1'b0;
        game_lost_d      = game_lost_q;
        game_won_d       = game_won_q;
        tmr_start        = 1'b0;
        tmr_load         = '0;

        case (state_q)
            IDLE, LOST, WON: begin
                if (gf.start) begin
                    state_d          = PLAY;
                    lives_d          = LIVES_W'(NUM_LIVES);
                    wave_d           = WAVE_W'(1);
                    wave_start_d     = 1'b1;
                    player_respawn_d = 1'b1;
                    game_lost_d      = 1'b0;
                    game_won_d       = 1'b0;
                end
            end
            PLAY: begin
                if (gf.invaders_landed) begin
                    state_d     = LOST;
                    lives_d     = '0;
                    game_lost_d = 1'b1;
                end else if (gf.player_hit) begin
                    if (lives_q != '0) begin
                        lives_d = lives_q - LIVES_W'(1);
                    end
                    if (lives_q <= LIVES_W'(1)) begin
                        state_d     = LOST;
                        game_lost_d = 1'b1;
                    end else begin
                        state_d   = HIT_PAUSE;
                        tmr_start = 1'b1;
                        tmr_load  = TIMER_W'(RESPAWN_CYCLES - 1);
                    end
                // The grid is still being re-populated during the cycle that shows wave_start.
                end else if (grid_empty && !wave_start_q) begin
                    if (wave_q == WAVE_W'(NUM_WAVES)) begin
                        state_d    = WON;
                        game_won_d = 1'b1;
                    end else begin
                        state_d   = CLEAR_PAUSE;
                        tmr_start = 1'b1;
                        tmr_load  = TIMER_W'(CLEAR_CYCLES - 1);
                    end
                end
            end
            HIT_PAUSE: begin
                if (tmr_done) begin
                    state_d          = PLAY;
                    player_respawn_d = 1'b1;
                end
            end
            CLEAR_PAUSE: begin
                if (tmr_done) begin
                    state_d      = PLAY;
                    wave_d       = wave_q + WAVE_W'(1);
                    wave_start_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        freeze_d = (state_d != PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            lives_q          <= '0;
            wave_q           <= '0;
            freeze_q         <= 1'b1;
            wave_start_q     <= 1'b0;
            player_respawn_q <= 1'b0;
            game_lost_q      <= 1'b0;
            game_won_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            lives_q          <= lives_d;
            wave_q           <= wave_d;
            freeze_q         <= freeze_d;
            wave_start_q     <= wave_start_d;
            player_respawn_q <= player_respawn_d;
            game_lost_q      <= game_lost_d;
            game_won_q       <= game_won_d;
        end
    end

    assign gf.state          = state_q;
    assign gf.lives          = lives_q;
    assign gf.wave           = wave_q;
    assign gf.freeze         = freeze_q;
    assign gf.wave_start     = wave_start_q;
    assign gf.player_respawn = player_respawn_q;
    assign gf.game_lost      = game_lost_q;
    assign gf.game_won       = game_won_q;

endmodule
